// File: rtl/cpu_state_seq_pkg.sv
// Shared definitions for the CPU state sequencer and the start/stop circuit.
// Holds the 2-bit state encodings and the instruction-count width.
package cpu_state_seq_pkg;

    localparam logic [1:0] ST_FETCH   = 2'b00;
    localparam logic [1:0] ST_DECODE  = 2'b01;
    localparam logic [1:0] ST_EXECUTE = 2'b10;
    localparam logic [1:0] ST_IDLE    = 2'b11;

    localparam int CNT_W = 16;

endpackage

// File: rtl/cpu_state_seq.sv
// CPU instruction sequencer: IDLE -> FETCH -> DECODE -> EXECUTE loop
// with memory wait, freeze, single-step, halt and instruction counter.
module cpu_state_seq
    import cpu_state_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             run_en,
    input  logic             start,
    input  logic             step_mode,
    input  logic             mem_busy,
    input  logic             halt_op,
    output logic [1:0]       cpustate,
    output logic             stop_req,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt
);

    logic [1:0] state_d;
    logic       complete;
    logic       stop_d;
    logic       go;

    assign go       = (cpustate == ST_IDLE) && start;
    assign complete = (cpustate == ST_EXECUTE) && run_en && !mem_busy;
    assign stop_d   = complete && (halt_op || step_mode);

    // Next-state selection; run_en gates every non-idle transition
    always_comb begin
        state_d = cpustate;
        unique case (cpustate)
            ST_IDLE: begin
                if (start)
                    state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (run_en && !mem_busy)
                    state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (run_en)
                    state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (complete)
                    state_d = halt_op ? ST_IDLE : ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            cpustate <= ST_IDLE;
        else
            cpustate <= state_d;
    end

    // Registered one-cycle stop request on halt or single-step completion
    always_ff @(posedge clk) begin
        if (rst)
            stop_req <= 1'b0;
        else
            stop_req <= stop_d;
    end

    // Sticky halt flag: cleared by a start from IDLE, set by HLT completion
    always_ff @(posedge clk) begin
        if (rst)
            halted <= 1'b0;
        else if (go)
            halted <= 1'b0;
        else if (complete && halt_op)
            halted <= 1'b1;
    end

    // Completed-instruction counter, wraps silently
    always_ff @(posedge clk) begin
        if (rst)
            instr_cnt <= '0;
        else if (complete)
            instr_cnt <= instr_cnt + 1'b1;
    end

endmodule

// File: doc/cpu_state_seq.md
CPU_STATE_SEQ -- requirements
Module: cpu_state_seq

Interface
REQ-001 The block SHALL use exactly one clock and one reset, both listed first: reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 run_en  input  1  advance enable from the start/stop circuit; 1 = sequencer may advance, 0 = freeze.
REQ-005 start  input  1  one-cycle start pulse; meaningful only in IDLE.
REQ-006 step_mode  input  1  1 = single-instruction mode.
REQ-007 mem_busy  input  1  memory wait; 1 = hold current FETCH/EXECUTE state.
REQ-008 halt_op  input  1  decoded HLT instruction, sampled in EXECUTE.
REQ-009 cpustate  output  2  00 FETCH, 01 DECODE, 10 EXECUTE, 11 IDLE.
REQ-010 stop_req  output  1  one-cycle active-high stop request to the start/stop circuit (its clr input).
REQ-011 halted  output  1  sticky flag; set by HLT completion.
REQ-012 instr_cnt  output  16  count of completed instructions.

Function
REQ-013 IDLE SHALL go to FETCH on start=1, clearing halted in the same edge; run_en is ignored in IDLE.
REQ-014 In FETCH, DECODE and EXECUTE, run_en=0 SHALL freeze cpustate, halted and instr_cnt, and SHALL force stop_req=0.
REQ-015 FETCH SHALL go to DECODE when run_en=1 and mem_busy=0, and SHALL otherwise hold.
REQ-016 DECODE SHALL go to EXECUTE after one enabled cycle; mem_busy SHALL be ignored in DECODE.
REQ-017 EXECUTE SHALL hold while mem_busy=1, and SHALL complete on the first enabled cycle with mem_busy=0.
REQ-018 On EXECUTE completion, instr_cnt SHALL increment by 1, wrapping modulo 2^16 (0xFFFF -> 0x0000) with no flag.
REQ-019 On EXECUTE completion with halt_op=1, the block SHALL go to IDLE, set halted, and pulse stop_req.
REQ-020 On EXECUTE completion with halt_op=0 and step_mode=1, the block SHALL go to FETCH and pulse stop_req.
REQ-021 On EXECUTE completion with halt_op=0 and step_mode=0, the block SHALL go to FETCH with no stop_req.
REQ-022 halt_op SHALL take priority over step_mode when both are 1.
REQ-023 stop_req SHALL be registered, high for exactly the cycle after the completing edge, and never high on two consecutive cycles.
REQ-024 start outside IDLE SHALL have no effect; start and halt completion in the same cycle SHALL resolve to IDLE with halted=1.
REQ-025 Minimum instruction latency SHALL be 3 enabled cycles (FETCH, DECODE, EXECUTE); each mem_busy cycle adds one.

Reset
REQ-026 rst=1 at a clock edge SHALL force cpustate=11, stop_req=0, halted=0 and instr_cnt=0, overriding every other input including mid-instruction.
REQ-027 After rst is released, the block SHALL stay in IDLE until the first start pulse.

Structure
REQ-028 The 2-bit state encodings (FETCH, DECODE, EXECUTE, IDLE) SHALL be defined in a shared package used by this block and the start/stop circuit.
REQ-029 The 16-bit instruction-count width SHALL be a package constant.
REQ-030 The block SHALL be a single module with no sub-modules: one state register, a next-state process, the registered stop_req, and the counter.

Verification
REQ-031 Release reset, then pulse start with run_en=1 and mem_busy=0 -> cpustate sequence 11, 00, 01, 10, 00; instr_cnt=1 after the first completion.
REQ-032 Hold mem_busy=1 for 3 cycles in FETCH -> cpustate stays 00 for 4 cycles total; latency for that instruction is 6.
REQ-033 Set halt_op=1 in EXECUTE -> next cpustate=11, halted=1, stop_req high for 1 cycle; a later start -> halted=0, cpustate=00.
REQ-034 Set step_mode=1 -> stop_req pulses once per instruction; dropping run_en for 5 cycles mid-DECODE -> state and counter unchanged, stop_req=0.
REQ-035 Preload the counter near 0xFFFF and complete 2 instructions -> instr_cnt goes 0xFFFF then 0x0000.
REQ-036 Assert rst during EXECUTE with mem_busy=1 -> next cycle cpustate=11, instr_cnt=0, halted=0, stop_req=0.
